// File: rtl/cell_bist_pkg.sv
// Purpose: shared types and constants for the cell BIST controller (state enum, polynomial, seeds).
// Latency: n/a (package only).
// Backpressure: n/a.
package cell_bist_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Galois feedback taps shared by the stimulus generator and the MISR
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  // Stimulus generator start value
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Signature register start value
  localparam logic [15:0] MISR_SEED = 16'h0000;

  // One Galois right-shift step without parallel input
  function automatic logic [15:0] shift_step(input logic [15:0] x);
    return {1'b0, x[15:1]} ^ (x[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cell_bist_lfsr16.sv
// Purpose: 16-bit Galois shift register with parallel XOR input; serves as LFSR (din=0) or MISR (din=response).
// Latency: one cycle per step; load and reset both return to SEED.
// Backpressure: none; en=0 holds the register.
module cell_bist_lfsr16
  import cell_bist_pkg::*;
#(
  parameter logic [15:0] SEED = 16'h0000,
  parameter int          QW   = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load,
  input  logic          en,
  input  logic [15:0]   din,
  output logic [QW-1:0] q
);

  logic [15:0] r;

  // Register: reset/load to seed, otherwise step when enabled
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r <= SEED;
    end else if (load) begin
      r <= SEED;
    end else if (en) begin
      r <= shift_step(r) ^ din;
    end
  end

  // Only the low QW bits leave the block; the full register keeps feeding back internally
  assign q = r[QW-1:0];

endmodule

// File: rtl/cell_bist_ctrl.sv
// Purpose: BIST run controller: drives LFSR stimulus into a cell cluster, compresses responses in a MISR, compares to GOLDEN.
// Latency: STIM-to-capture one cycle; BUSY high for NPAT cycles (plus any HOLD cycles), then DONE.
// Backpressure: optional HOLD input (build macro CELL_BIST_HOLD_EN) freezes a run; START is ignored while running.
module cell_bist_ctrl
  import cell_bist_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OUTW  = 8,
  parameter int NPAT  = 256
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [15:0]      GOLDEN,
  input  logic [OUTW-1:0]  RESP,
`ifdef CELL_BIST_HOLD_EN
  input  logic             HOLD,
`endif
  output logic [WIDTH-1:0] STIM,
  output logic             BUSY,
  output logic             DONE,
  output logic [15:0]      SIG,
  output logic             PASS
);

  localparam logic [15:0] LAST_CNT = 16'(NPAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] cnt;
  logic        start_acc;
  logic        run_adv;
  logic        run_ok;
  logic        last_pat;
  logic [15:0] resp_ext;
  logic [15:0] misr_q;

  // Decide whether a RUN cycle is allowed to advance this edge
`ifdef CELL_BIST_HOLD_EN
  assign run_ok = ~HOLD;
`else
  assign run_ok = 1'b1;
`endif

  // The capture on which cnt reaches NPAT-1 is the final pattern of the run
  assign last_pat = (cnt == LAST_CNT);

  // Next-state logic and status outputs
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    run_adv   = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (START) begin
          start_acc = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        BUSY = 1'b1;
        if (run_ok) begin
          run_adv = 1'b1;
          if (last_pat) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        DONE = 1'b1;
        if (START) begin
          start_acc = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pattern counter: cleared on run start, counts captured patterns; the terminal count stops it before wrap
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= 16'h0000;
    end else if (start_acc) begin
      cnt <= 16'h0000;
    end else if (run_adv) begin
      cnt <= cnt + 16'h0001;
    end
  end

  // Zero-extend the cluster response to the MISR width
  always_comb begin
    resp_ext           = 16'h0000;
    resp_ext[OUTW-1:0] = RESP;
  end

  // Stimulus generator: free-running LFSR with no parallel input
  cell_bist_lfsr16 #(
    .SEED (LFSR_SEED),
    .QW   (WIDTH)
  ) u_gen (
    .CLK  (CLK),
    .RST  (RST),
    .load (start_acc),
    .en   (run_adv),
    .din  (16'h0000),
    .q    (STIM)
  );

  // Signature register: same step, response folded in each RUN cycle
  cell_bist_lfsr16 #(
    .SEED (MISR_SEED),
    .QW   (16)
  ) u_misr (
    .CLK  (CLK),
    .RST  (RST),
    .load (start_acc),
    .en   (run_adv),
    .din  (resp_ext),
    .q    (misr_q)
  );

  assign SIG = misr_q;

  // Verdict only meaningful once the run has finished; GOLDEN is expected static across DONE
  assign PASS = (state == ST_DONE) && (misr_q == GOLDEN);

endmodule

// File: tb/tb_cell_bist_ctrl.sv
// Purpose: self-checking bench for cell_bist_ctrl with a pattern-index reference model.
// Latency: n/a.
// Backpressure: exercises HOLD only when CELL_BIST_HOLD_EN is defined.
module tb_cell_bist_ctrl;

  localparam int WIDTH = 8;
  localparam int OUTW  = 8;
  localparam int NPAT  = 256;

  logic             CLK    = 1'b0;
  logic             RST    = 1'b0;
  logic             START  = 1'b0;
  logic             hold   = 1'b0;
  logic             mode   = 1'b0;
  logic [15:0]      GOLDEN = 16'h0000;
  logic [OUTW-1:0]  RESP;
  logic [WIDTH-1:0] STIM;
  logic             BUSY;
  logic             DONE;
  logic [15:0]      SIG;
  logic             PASS;

  always #5 CLK = ~CLK;

  // Cluster stand-in: either silent or a straight loopback of the stimulus
  assign RESP = mode ? STIM : '0;

  cell_bist_ctrl #(.WIDTH(WIDTH), .OUTW(OUTW), .NPAT(NPAT)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .GOLDEN (GOLDEN),
    .RESP   (RESP),
`ifdef CELL_BIST_HOLD_EN
    .HOLD   (hold),
`endif
    .STIM   (STIM),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .SIG    (SIG),
    .PASS   (PASS)
  );

  int total = 0;
  int bad   = 0;
  int busy_total = 0;

  // Expected generator value and signature after k captured patterns
  logic [15:0] lf [0:NPAT];
  logic [15:0] ms [0:NPAT];

  function automatic logic [15:0] poly_step(input logic [15:0] x);
    return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic build(input logic m);
    lf[0] = 16'hACE1;
    ms[0] = 16'h0000;
    for (int k = 0; k < NPAT; k++) begin
      lf[k+1] = poly_step(lf[k]);
      ms[k+1] = poly_step(ms[k]) ^ (m ? {8'h00, lf[k][7:0]} : 16'h0000);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference: phase 0 idle, 1 run with k patterns captured, 2 done
  int          ph = 0;
  int          k  = 0;
  logic [15:0] dsig  = 16'h0000;
  logic [15:0] dstim = 16'h0000;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      ph = 0;
      k  = 0;
    end else if (ph == 1) begin
      if (!hold) begin
        k = k + 1;
        if (k == NPAT) begin
          ph    = 2;
          dsig  = ms[NPAT];
          dstim = lf[NPAT];
        end
      end
    end else if (START) begin
      ph = 1;
      k  = 0;
    end
  end

  task automatic run_start(output int base);
    @(posedge CLK);
    #1 base = busy_total;
    START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n;
    n = 0;
    while (n < maxc) begin
      @(negedge CLK);
      if (DONE === 1'b1) break;
      n++;
    end
    total++;
    if (DONE !== 1'b1) begin
      bad++;
      $display("FAIL wait_done: DONE=%b after %0d cycles, want 1", DONE, n);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_stim"}, STIM, 8'hE1);
    chk({tag, "_busy"}, BUSY, 1'b0);
    chk({tag, "_done"}, DONE, 1'b0);
    chk({tag, "_sig"},  SIG,  16'h0000);
    chk({tag, "_pass"}, PASS, 1'b0);
  endtask

  logic [15:0] sig1;
  int          base;
  logic [15:0] estim, esig;
  logic        ebusy, edone, epass;

  initial begin
    RST = 1'b1;
    // Per-cycle compare and BUSY length monitor
    fork
      forever begin
        @(negedge CLK);
        if (BUSY === 1'b1) busy_total++;
        ebusy = (ph == 1);
        edone = (ph == 2);
        if (ph == 1) begin
          estim = lf[k];
          esig  = ms[k];
        end else if (ph == 2) begin
          estim = dstim;
          esig  = dsig;
        end else begin
          estim = 16'hACE1;
          esig  = 16'h0000;
        end
        epass = edone && (esig == GOLDEN);
        chk("cyc_busy", BUSY, ebusy);
        chk("cyc_done", DONE, edone);
        chk("cyc_stim", STIM, estim[WIDTH-1:0]);
        chk("cyc_sig",  SIG,  esig);
        chk("cyc_pass", PASS, epass);
      end
    join_none

    build(1'b0);
    chk("model_lf1", lf[1], 16'hE270);
    chk("model_lf2", lf[2], 16'h7138);

    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk_idle("reset");

    // Silent cluster, GOLDEN 0; a START mid-run must be ignored
    mode = 1'b0;
    GOLDEN = 16'h0000;
    run_start(base);
    chk("start_busy", BUSY, 1'b1);
    chk("stim_first", STIM, 8'hE1);
    @(posedge CLK);
    #1 chk("stim_second", STIM, 8'h70);
    repeat (20) @(posedge CLK);
    #1 START = 1'b1;
    @(posedge CLK);
    #1 START = 1'b0;
    wait_done(NPAT + 20);
    chk("zero_busy_len", busy_total - base, NPAT);
    chk("zero_done", DONE, 1'b1);
    chk("zero_sig", SIG, 16'h0000);
    chk("zero_pass", PASS, 1'b1);

    // Loopback with matching GOLDEN, then a repeat with GOLDEN off by one bit
    @(posedge CLK);
    #1 mode = 1'b1;
    build(1'b1);
    GOLDEN = ms[NPAT];
    run_start(base);
    wait_done(NPAT + 20);
    chk("loop_pass", PASS, 1'b1);
    chk("loop_busy_len", busy_total - base, NPAT);
    sig1 = SIG;
    @(posedge CLK);
    #1 GOLDEN = GOLDEN ^ 16'h0001;
    run_start(base);
    wait_done(NPAT + 20);
    chk("loop_fail_pass", PASS, 1'b0);
    chk("loop_repeat_sig", SIG, sig1);

    // Reset in the middle of a run, START on the first edge after release
    GOLDEN = sig1;
    run_start(base);
    repeat (99) @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    chk_idle("midrst");
    @(posedge CLK);
    #1 RST = 1'b0;
    START = 1'b1;
    base = busy_total;
    @(posedge CLK);
    #1 START = 1'b0;
    chk("post_rst_busy", BUSY, 1'b1);
    wait_done(NPAT + 20);
    chk("post_rst_sig", SIG, sig1);
    chk("post_rst_pass", PASS, 1'b1);
    chk("post_rst_busy_len", busy_total - base, NPAT);

`ifdef CELL_BIST_HOLD_EN
    // Ten frozen cycles stretch the run but leave the signature unchanged
    run_start(base);
    repeat (50) @(posedge CLK);
    #1 hold = 1'b1;
    START = 1'b1;
    repeat (10) @(posedge CLK);
    #1 hold = 1'b0;
    START = 1'b0;
    wait_done(NPAT + 40);
    chk("hold_busy_len", busy_total - base, NPAT + 10);
    chk("hold_sig", SIG, sig1);
    chk("hold_pass", PASS, 1'b1);
`endif

    @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
